instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Sequential instruction encoder; the inverse of the sign-extension/immediate-extraction path.
- Accepts a decoded LEGv8 operation (op, registers, 64-bit signed immediate) and packs it into a 32-bit instruction word with the correct opcode and immediate field.
- Streams encoded words out with a byte address for loading instruction memory.
- Used by the program loader and as a stimulus generator for datapath benches.

Parameters:
- ADDR_W, 64, width of the output byte address counter.
- BASE_ADDR, 0, address loaded into the counter at reset; must be a multiple of 4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  encoder can accept an input this cycle.
- in_op  in  3  operation: 0 CBZ, 1 LDUR, 2 STUR, 3 ADDI, 4..7 illegal.
- in_rd  in  5  Rt (CBZ, LDUR, STUR) or Rd (ADDI).
- in_rn  in  5  Rn base/source register; ignored for CBZ.
- in_imm  in  64  signed immediate, two's complement.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address of out_instr.
- err  out  1  one-cycle pulse when an input is rejected.
- err_count  out  8  saturating count of rejected inputs.

Behaviour:
- Reset (async, reset low) sets: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = !out_valid | out_ready. Combinational; no dependence on in_valid.
  - Once out_valid is high, out_instr and out_addr hold stable until transferred.
- Latency: 1 cycle. An accepted legal input appears on out_instr with out_valid=1 on the next rising edge.
  - Back-to-back throughput: 1 word/cycle while out_ready=1.
- Encoding:
  - CBZ: {8'b10110100, imm[18:0], rd}.
  - LDUR: {11'b11111000010, imm[8:0], 2'b00, rn, rd}.
  - STUR: {11'b11111000000, imm[8:0], 2'b00, rn, rd}.
  - ADDI: {10'b1001000100, imm[11:0], rn, rd}.
- Range check (signed, all ops):
  - Immediate legal iff in_imm[63:N-1] are all equal, with N=19 (CBZ), 9 (LDUR/STUR), 12 (ADDI).
  - ADDI range is therefore -2048..2047, so words round-trip through sign extension.
- Rejection: an accepted input with an illegal op or out-of-range immediate:
  - produces no output word;
  - sets out_valid=0 on the next cycle if no other word is pending;
  - pulses err=1 for exactly one cycle;
  - increments err_count, saturating at 255.
  - out_addr does not advance.
- Address:
  - out_addr increments by 4 on each output transfer.
  - Wraps modulo 2^ADDR_W with no flag.
  - Simultaneous output transfer and legal input acceptance: the new word is presented with the incremented address.
- Stall: out_valid=1 & out_ready=0 drives in_ready=0. Inputs are not sampled while stalled.
- Reset mid-operation: a pending word is discarded and the address returns to BASE_ADDR. Nothing is replayed.

Optional Feature:
- Macro: INSTR_ENCODER_ROUNDTRIP_CHECK_EN.
- When defined:
  - Adds output chk_fail (1 bit, reset 0).
  - Each registered word is re-extracted by instruction format (same field positions as above), sign-extended to 64 bits and compared with the stored in_imm.
  - Mismatch sets chk_fail=1 in the same cycle out_valid rises; chk_fail is sticky until reset.
- When undefined: no chk_fail port, no comparator logic. All other behaviour is identical.

Test Plan:
- Reset, then CBZ imm=23 rd=1 with out_ready=1 -> next cycle out_valid=1, out_instr=32'hB40002E1, out_addr=0.
- CBZ imm=-23 rd=1 -> 32'hB4FFFD21; LDUR imm=23 rn=2 rd=1 -> 32'hF8417041. Back-to-back, addresses 0, 4.
- STUR imm=-23 rn=2 rd=1 -> 32'hF81E9041; ADDI imm=23 rn=1 rd=1 -> 32'h91005C21.
- ADDI imm=2048, then op=5 -> no out_valid, two err pulses, err_count=2, out_addr unchanged. LDUR imm=256 -> rejected; imm=-256 -> accepted, field 9'h100.
- Hold out_ready=0 for 3 cycles with a word pending -> in_ready=0, out_instr and out_addr stable. Release -> transfer, addr+4.
- ADDR_W=4 with BASE_ADDR=12, two transfers -> addresses 12, 0. Assert reset mid-stall -> out_valid=0 immediately, addr=12.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake bundle between a producer of decoded LEGv8 operations and the
// instruction encoder. The encoder sits on the slave modport; the loader or
// bench that feeds it sits on the master modport.
interface instr_encoder_if #(
  parameter int ADDR_W = 64
);
  // input side: decoded operation
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [63:0]       in_imm;
  // output side: encoded word and its byte address
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs a decoded LEGv8 operation (CBZ/LDUR/STUR/ADDI) into a
// 32-bit instruction word and streams it out with a byte address for
// instruction-memory loading. One register stage; 1 word/cycle throughput.
// Inputs whose op is illegal or whose immediate does not fit the field are
// dropped, flagged with a one-cycle err pulse and counted (saturating).
// Optional: define INSTR_ENCODER_ROUNDTRIP_CHECK_EN to add a sticky chk_fail
// output that re-extracts each registered immediate and compares it against
// the input immediate.
module instr_encoder #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_encoder_if.slave       bus,
  output logic                 err,
  output logic [7:0]           err_count
`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
  ,
  output logic                 chk_fail
`endif
);

  localparam logic [2:0] OP_CBZ  = 3'd0;
  localparam logic [2:0] OP_LDUR = 3'd1;
  localparam logic [2:0] OP_STUR = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [63:0] imm;
  } req_t;

  // True when v is representable as an n-bit two's complement value,
  // i.e. bits [63:n-1] are all copies of the sign.
  function automatic logic fits(input logic [63:0] v, input int n);
    logic [63:0] hi;
    hi = $signed(v) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  req_t              req;
  logic [31:0]       word;
  logic              op_ok;
  logic              imm_ok;
  logic              legal;
  logic              acc;
  logic              xfer;
  logic              rdy;

  logic              vld_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] addr_q;

  assign req = '{op: bus.in_op, rd: bus.in_rd, rn: bus.in_rn, imm: bus.in_imm};

  // Format selection and immediate range check for the incoming operation.
  always_comb begin
    word   = '0;
    op_ok  = 1'b1;
    imm_ok = 1'b0;
    case (req.op)
      OP_CBZ: begin
        word   = {8'b10110100, req.imm[18:0], req.rd};
        imm_ok = fits(req.imm, 19);
      end
      OP_LDUR: begin
        word   = {11'b11111000010, req.imm[8:0], 2'b00, req.rn, req.rd};
        imm_ok = fits(req.imm, 9);
      end
      OP_STUR: begin
        word   = {11'b11111000000, req.imm[8:0], 2'b00, req.rn, req.rd};
        imm_ok = fits(req.imm, 9);
      end
      OP_ADDI: begin
        word   = {10'b1001000100, req.imm[11:0], req.rn, req.rd};
        imm_ok = fits(req.imm, 12);
      end
      default: op_ok = 1'b0;
    endcase
  end

  assign legal = op_ok & imm_ok;

  // Ready only looks at the output stage so the producer never sees a
  // combinational path from its own valid back to ready.
  assign rdy  = !vld_q | bus.out_ready;
  assign acc  = bus.in_valid & rdy;
  assign xfer = vld_q & bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;

  // Byte address of the presented word; advances only when a word leaves,
  // so a word accepted alongside a transfer lands at the next address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    addr_q <= BASE_ADDR;
    else if (xfer) addr_q <= addr_q + ADDR_W'(4);
  end

  // Output word register. Held stable while stalled because acc is low then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q   <= 1'b0;
      instr_q <= '0;
    end else if (acc && legal) begin
      vld_q   <= 1'b1;
      instr_q <= word;
    end else if (xfer) begin
      vld_q   <= 1'b0;
    end
  end

  // Rejection pulse and saturating reject counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= acc & !legal;
      if (acc && !legal && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

`ifdef INSTR_ENCODER_ROUNDTRIP_CHECK_EN
  // Pull the immediate field back out of a word by format and sign-extend it,
  // exactly as the decode/sign-extension path would.
  function automatic logic [63:0] rt_imm(input logic [2:0] op, input logic [31:0] w);
    logic [63:0] r;
    case (op)
      OP_CBZ:           r = {{45{w[23]}}, w[23:5]};
      OP_LDUR, OP_STUR: r = {{55{w[20]}}, w[20:12]};
      default:          r = {{52{w[21]}}, w[21:10]};
    endcase
    return r;
  endfunction

  // Sticky round-trip mismatch flag, set on the edge that raises out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      chk_fail <= 1'b0;
    else if (acc && legal && (rt_imm(req.op, word) != req.imm))
      chk_fail <= 1'b1;
  end
`endif

endmodule
